// File: rtl/priority_encoder_stream.sv
// Streams the index of every set bit of an accepted request bitmap, lowest index
// first, one beat per cycle under valid/ready flow control on both sides.
module priority_encoder_stream #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_bits,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_last,
   output logic         zero_drop
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t       state_q, state_d;
   logic [N-1:0] pending_q, pending_d;
   logic         zero_drop_q, zero_drop_d;

   logic [W-1:0] low_idx;
   logic         low_found;
   logic         single_bit;
   logic         in_fire;
   logic         out_fire;

   // Lowest pending index and the last-beat flag come only from registered state.
   always_comb begin
      low_idx   = '0;
      low_found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (pending_q[i] && !low_found) begin
            low_idx   = W'(i);
            low_found = 1'b1;
         end
      end
      single_bit = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
   end

   // Reset masks the outputs in the same cycle so no beat can complete during reset.
   always_comb begin
      in_ready  = (state_q == IDLE) && !reset;
      out_valid = (state_q == EMIT) && !reset;
      out_idx   = out_valid ? low_idx : '0;
      out_last  = out_valid && single_bit;
      zero_drop = zero_drop_q && !reset;
      in_fire   = in_valid && in_ready;
      out_fire  = out_valid && out_ready;
   end

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      zero_drop_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_fire) begin
               if (in_bits != '0) begin
                  pending_d = in_bits;
                  state_d   = EMIT;
               end else begin
                  zero_drop_d = 1'b1;
               end
            end
         end
         EMIT: begin
            if (out_fire) begin
               // Clearing the lowest set bit is the same as clearing pending[out_idx].
               pending_d = pending_q & (pending_q - N'(1));
               if (single_bit) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         zero_drop_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         zero_drop_q <= zero_drop_d;
      end
   end

endmodule
